// File: rtl/rob_tag_allocator.sv
// AR-side tag allocator for the read reorder buffer: binds each master AR to the lowest
// free internal tag, forwards it through a one-entry output slot and records orig ID/len.
module rob_tag_allocator #(
    parameter int unsigned ID_WIDTH        = 4,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned LEN_WIDTH       = 8,
    parameter int unsigned TAG_WIDTH       = 4,
    parameter int unsigned MAX_OUTSTANDING = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ID_WIDTH-1:0]   in_id,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [LEN_WIDTH-1:0]  in_len,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [TAG_WIDTH-1:0]  out_tag,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [LEN_WIDTH-1:0]  out_len,
    output logic                  alloc_valid,
    output logic [TAG_WIDTH-1:0]  alloc_tag,
    output logic [ID_WIDTH-1:0]   alloc_orig_id,
    output logic [LEN_WIDTH-1:0]  alloc_len,
    input  logic                  free_valid,
    input  logic [TAG_WIDTH-1:0]  free_tag,
    input  logic [TAG_WIDTH-1:0]  lookup_tag,
    output logic [ID_WIDTH-1:0]   lookup_orig_id,
    output logic [TAG_WIDTH:0]    used_count,
    output logic                  full,
    output logic                  err_bad_free
);

    localparam logic [TAG_WIDTH:0] MaxCount = (TAG_WIDTH + 1)'(MAX_OUTSTANDING);

    logic [MAX_OUTSTANDING-1:0] used_q, used_d;
    logic [ID_WIDTH-1:0]        orig_id_q [MAX_OUTSTANDING];
    logic [LEN_WIDTH-1:0]       len_q [MAX_OUTSTANDING];
    logic [TAG_WIDTH:0]         used_count_q, used_count_d;
    logic                       err_q;

    logic                  out_valid_q;
    logic [TAG_WIDTH-1:0]  out_tag_q;
    logic [ADDR_WIDTH-1:0] out_addr_q;
    logic [LEN_WIDTH-1:0]  out_len_q;
    logic                  alloc_valid_q;
    logic [TAG_WIDTH-1:0]  alloc_tag_q;
    logic [ID_WIDTH-1:0]   alloc_orig_id_q;
    logic [LEN_WIDTH-1:0]  alloc_len_q;

    logic                 accept;
    logic                 free_ok;
    logic [TAG_WIDTH-1:0] alloc_idx;

    assign full     = (used_count_q == MaxCount);
    assign in_ready = !full && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign free_ok  = free_valid && used_q[free_tag];

    // Lowest-index free tag; looks at pre-edge state so same-cycle frees are not reused.
    always_comb begin
        alloc_idx = '0;
        for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
            if (!used_q[i]) alloc_idx = TAG_WIDTH'(i);
        end
    end

    always_comb begin
        used_d = used_q;
        if (accept)  used_d[alloc_idx] = 1'b1;
        if (free_ok) used_d[free_tag]  = 1'b0;
    end

    always_comb begin
        used_count_d = used_count_q;
        case ({accept, free_ok})
            2'b10:   used_count_d = used_count_q + 1'b1;
            2'b01:   used_count_d = used_count_q - 1'b1;
            default: used_count_d = used_count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            used_q          <= '0;
            used_count_q    <= '0;
            err_q           <= 1'b0;
            out_valid_q     <= 1'b0;
            out_tag_q       <= '0;
            out_addr_q      <= '0;
            out_len_q       <= '0;
            alloc_valid_q   <= 1'b0;
            alloc_tag_q     <= '0;
            alloc_orig_id_q <= '0;
            alloc_len_q     <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                orig_id_q[i] <= '0;
                len_q[i]     <= '0;
            end
        end else begin
            used_q        <= used_d;
            used_count_q  <= used_count_d;
            alloc_valid_q <= accept;
            if (free_valid && !used_q[free_tag]) err_q <= 1'b1;
            if (accept) begin
                orig_id_q[alloc_idx] <= in_id;
                len_q[alloc_idx]     <= in_len;
                out_valid_q          <= 1'b1;
                out_tag_q            <= alloc_idx;
                out_addr_q           <= in_addr;
                out_len_q            <= in_len;
                alloc_tag_q          <= alloc_idx;
                alloc_orig_id_q      <= in_id;
                alloc_len_q          <= in_len;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid      = out_valid_q;
    assign out_tag        = out_tag_q;
    assign out_addr       = out_addr_q;
    assign out_len        = out_len_q;
    assign alloc_valid    = alloc_valid_q;
    assign alloc_tag      = alloc_tag_q;
    assign alloc_orig_id  = alloc_orig_id_q;
    assign alloc_len      = alloc_len_q;
    assign lookup_orig_id = orig_id_q[lookup_tag];
    assign used_count     = used_count_q;
    assign err_bad_free   = err_q;

endmodule

// File: tb/tb_rob_tag_allocator.sv
// Bench for rob_tag_allocator: a tag-pool model checked every cycle plus directed
// scenarios with literal expectations.
module tb_rob_tag_allocator;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [3:0]  in_id;
    logic [31:0] in_addr;
    logic [7:0]  in_len;
    logic        out_valid, out_ready;
    logic [3:0]  out_tag;
    logic [31:0] out_addr;
    logic [7:0]  out_len;
    logic        alloc_valid;
    logic [3:0]  alloc_tag, alloc_orig_id;
    logic [7:0]  alloc_len;
    logic        free_valid;
    logic [3:0]  free_tag, lookup_tag, lookup_orig_id;
    logic [4:0]  used_count;
    logic        full, err_bad_free;

    rob_tag_allocator dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_id(in_id), .in_addr(in_addr),
        .in_len(in_len),
        .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
        .out_addr(out_addr), .out_len(out_len),
        .alloc_valid(alloc_valid), .alloc_tag(alloc_tag), .alloc_orig_id(alloc_orig_id),
        .alloc_len(alloc_len),
        .free_valid(free_valid), .free_tag(free_tag),
        .lookup_tag(lookup_tag), .lookup_orig_id(lookup_orig_id),
        .used_count(used_count), .full(full), .err_bad_free(err_bad_free)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a set of busy tags with their bindings, and the slot a slave is offered.
    bit          m_used [16];
    logic [3:0]  m_orig [16];
    bit          m_ov, m_av, m_err;
    logic [3:0]  m_otag, m_atag, m_aid;
    logic [31:0] m_oaddr;
    logic [7:0]  m_olen, m_alen;
    bit          started = 0;

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < 16; i++) n += int'(m_used[i]);
        return n;
    endfunction

    function automatic bit m_ready();
        return (m_count() < 16) && (!m_ov || out_ready);
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) begin
                m_used[i] = 0;
                m_orig[i] = '0;
            end
            {m_ov, m_av, m_err} = '0;
            {m_otag, m_atag, m_aid, m_oaddr, m_olen, m_alen} = '0;
            started = 1;
        end else begin
            bit acc;
            bit rel;
            int t;
            acc = in_valid && m_ready();
            rel = free_valid && m_used[free_tag];
            if (free_valid && !m_used[free_tag]) m_err = 1;
            t = 0;
            while (t < 16 && m_used[t]) t++;
            if (rel) m_used[free_tag] = 0;
            m_av = acc;
            if (acc) begin
                m_used[t] = 1;
                m_orig[t] = in_id;
                m_ov = 1;
                m_otag = 4'(t);
                m_oaddr = in_addr;
                m_olen = in_len;
                m_atag = 4'(t);
                m_aid = in_id;
                m_alen = in_len;
            end else if (out_ready) begin
                m_ov = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("m_out_valid", 64'(out_valid), 64'(m_ov));
            check("m_out_tag", 64'(out_tag), 64'(m_otag));
            check("m_out_addr", 64'(out_addr), 64'(m_oaddr));
            check("m_out_len", 64'(out_len), 64'(m_olen));
            check("m_alloc_valid", 64'(alloc_valid), 64'(m_av));
            check("m_alloc_tag", 64'(alloc_tag), 64'(m_atag));
            check("m_alloc_orig_id", 64'(alloc_orig_id), 64'(m_aid));
            check("m_alloc_len", 64'(alloc_len), 64'(m_alen));
            check("m_used_count", 64'(used_count), 64'(m_count()));
            check("m_full", 64'(full), 64'(m_count() == 16));
            check("m_err_bad_free", 64'(err_bad_free), 64'(m_err));
            check("m_in_ready", 64'(in_ready), 64'(m_ready()));
            check("m_lookup", 64'(lookup_orig_id), 64'(m_orig[lookup_tag]));
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
        in_valid = 1'b1;
        in_id = id;
        in_addr = addr;
        in_len = len;
    endtask

    task automatic free1(input logic [3:0] t);
        free_valid = 1'b1;
        free_tag = t;
        cycle();
        free_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        in_valid = 1'b0; in_id = '0; in_addr = '0; in_len = '0;
        out_ready = 1'b1; free_valid = 1'b0; free_tag = '0; lookup_tag = '0;
        cycle(); cycle();
        rst = 1'b1;
        check("rst_used_count", 64'(used_count), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_full", 64'(full), 64'd0);
        check("rst_err", 64'(err_bad_free), 64'd0);
        check("rst_out_addr", 64'(out_addr), 64'd0);

        // T1
        req(4'd0, 32'h1000, 8'd0);
        cycle();
        in_valid = 1'b0;
        check("t1_out_valid", 64'(out_valid), 64'd1);
        check("t1_out_tag", 64'(out_tag), 64'd0);
        check("t1_out_addr", 64'(out_addr), 64'h1000);
        check("t1_alloc_valid", 64'(alloc_valid), 64'd1);
        check("t1_alloc_orig_id", 64'(alloc_orig_id), 64'd0);
        check("t1_used_count", 64'(used_count), 64'd1);
        cycle();
        check("t1_alloc_pulse", 64'(alloc_valid), 64'd0);
        check("t1_out_drained", 64'(out_valid), 64'd0);
        free1(4'd0);

        // T2
        req(4'd3, 32'h2000, 8'd1);
        cycle();
        req(4'd3, 32'h3000, 8'd2);
        cycle();
        in_valid = 1'b0;
        check("t2_out_tag", 64'(out_tag), 64'd1);
        check("t2_used2", 64'(used_count), 64'd2);
        lookup_tag = 4'd0; #1;
        check("t2_lookup0", 64'(lookup_orig_id), 64'd3);
        lookup_tag = 4'd1; #1;
        check("t2_lookup1", 64'(lookup_orig_id), 64'd3);
        free1(4'd1);
        check("t2_used1", 64'(used_count), 64'd1);
        free1(4'd0);
        check("t2_used0", 64'(used_count), 64'd0);
        check("t2_err", 64'(err_bad_free), 64'd0);
        check("t2_lookup_after_free", 64'(lookup_orig_id), 64'd3);

        // T3
        for (int i = 0; i < 16; i++) begin
            req(4'(i), 32'(i * 256), 8'(i));
            cycle();
            check("t3_tag", 64'(out_tag), 64'(i));
        end
        in_valid = 1'b0; #1;
        check("t3_full", 64'(full), 64'd1);
        check("t3_used16", 64'(used_count), 64'd16);
        check("t3_in_ready", 64'(in_ready), 64'd0);
        free1(4'd5);
        check("t3_not_full", 64'(full), 64'd0);
        check("t3_ready_after_free", 64'(in_ready), 64'd1);
        req(4'd9, 32'h9000, 8'd9);
        cycle();
        in_valid = 1'b0;
        check("t3_reuse_tag5", 64'(out_tag), 64'd5);
        check("t3_full_again", 64'(full), 64'd1);
        for (int i = 0; i < 16; i++) free1(4'(i));
        check("t3_drained", 64'(used_count), 64'd0);

        // T4
        out_ready = 1'b0;
        req(4'd2, 32'h4000, 8'd3);
        cycle();
        req(4'd4, 32'h5000, 8'd4);
        for (int i = 0; i < 3; i++) begin
            check("t4_stall_ready", 64'(in_ready), 64'd0);
            check("t4_hold_addr", 64'(out_addr), 64'h4000);
            check("t4_hold_tag", 64'(out_tag), 64'd0);
            cycle();
        end
        out_ready = 1'b1; #1;
        check("t4_ready_same_cycle", 64'(in_ready), 64'd1);
        cycle();
        in_valid = 1'b0;
        check("t4_b2b_valid", 64'(out_valid), 64'd1);
        check("t4_b2b_tag", 64'(out_tag), 64'd1);
        check("t4_b2b_addr", 64'(out_addr), 64'h5000);
        cycle();
        check("t4_done", 64'(out_valid), 64'd0);
        free1(4'd0);
        free1(4'd1);

        // T5
        free1(4'd7);
        check("t5_err", 64'(err_bad_free), 64'd1);
        check("t5_used", 64'(used_count), 64'd0);
        for (int i = 0; i < 4; i++) begin
            req(4'(i + 8), 32'(32'hA000 + i), 8'(i));
            cycle();
        end
        check("t5_used4", 64'(used_count), 64'd4);
        req(4'd12, 32'hB000, 8'd7);
        free_valid = 1'b1;
        free_tag = 4'd2;
        cycle();
        in_valid = 1'b0;
        free_valid = 1'b0;
        check("t5_used_stays4", 64'(used_count), 64'd4);
        check("t5_tag4", 64'(out_tag), 64'd4);
        check("t5_err_sticky", 64'(err_bad_free), 64'd1);

        // T6
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req(4'd1, 32'(32'hC000 + i), 8'd0);
            cycle();
        end
        in_valid = 1'b0;
        check("t6_used3", 64'(used_count), 64'd3);
        check("t6_pending", 64'(out_valid), 64'd1);
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        check("t6_rst_valid", 64'(out_valid), 64'd0);
        check("t6_rst_used", 64'(used_count), 64'd0);
        check("t6_rst_err", 64'(err_bad_free), 64'd0);
        req(4'd6, 32'hD000, 8'd1);
        cycle();
        in_valid = 1'b0;
        check("t6_tag0", 64'(out_tag), 64'd0);
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
